// File: rtl/adder_serial_ctrl.sv
// ---------------------------------------------------------------------------
// adder_serial_ctrl
//
// Bit-serial add/subtract engine. A single 1-bit full adder, built from two
// half adders and an OR of their carries, is reused over DATA_WIDTH cycles,
// working from the least significant bit upwards. Operands come in and the
// result goes out over valid/ready handshakes.
//
// This file holds two modules:
//   adder_1bit_half    : combinational half adder (sum = a^b, cry = a&b)
//   adder_serial_ctrl  : the sequenced engine (top)
//
// adder_serial_ctrl ports:
//   i_clk     in   1           clock, rising edge
//   i_rst     in   1           synchronous active-high reset
//   i_valid   in   1           operand request valid
//   o_ready   out  1           engine can accept operands (IDLE)
//   i_num_a   in   DATA_WIDTH  operand a
//   i_num_b   in   DATA_WIDTH  operand b
//   i_cry     in   1           carry-in for add (ignored when subtracting)
//   i_sub     in   1           1 = a - b
//   o_valid   out  1           result valid (DONE)
//   i_ready   in   1           consumer accepts the result
//   o_res     out  DATA_WIDTH  sum / difference, modulo 2^DATA_WIDTH
//   o_cry     out  1           carry out of the MSB (subtract: 1 = no borrow)
//   o_ovf     out  1           signed overflow
// ---------------------------------------------------------------------------

module adder_1bit_half (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cry
);
    assign sum = a ^ b;
    assign cry = a & b;
endmodule

module adder_serial_ctrl #(
    parameter  int DATA_WIDTH = 32,
    localparam int CNT_WIDTH  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_num_a,
    input  logic [DATA_WIDTH-1:0] i_num_b,
    input  logic                  i_cry,
    input  logic                  i_sub,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_res,
    output logic                  o_cry,
    output logic                  o_ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);

    state_t                  state;
    state_t                  state_next;
    logic [CNT_WIDTH-1:0]    cnt;
    logic [DATA_WIDTH-1:0]   a_reg;
    logic [DATA_WIDTH-1:0]   b_reg;
    logic [DATA_WIDTH-1:0]   res_reg;
    logic                    carry;
    logic                    cry_reg;
    logic                    ovf_reg;
    logic                    accept;
    logic                    last_bit;

    logic                    ha0_sum;
    logic                    ha0_cry;
    logic                    fa_sum;
    logic                    ha1_cry;
    logic                    fa_cout;

    // The shared full adder: first half adder combines the operand bits,
    // the second folds in the running carry.
    adder_1bit_half u_ha0 (
        .a   (a_reg[cnt]),
        .b   (b_reg[cnt]),
        .sum (ha0_sum),
        .cry (ha0_cry)
    );

    adder_1bit_half u_ha1 (
        .a   (ha0_sum),
        .b   (carry),
        .sum (fa_sum),
        .cry (ha1_cry)
    );

    assign fa_cout  = ha0_cry | ha1_cry;
    assign last_bit = (cnt == LAST_BIT);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)   state_next = CALC;
            CALC:    if (last_bit) state_next = DONE;
            DONE:    if (i_ready)  state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded straight from the state
    always_comb begin
        o_ready = 1'b0;
        o_valid = 1'b0;
        case (state)
            IDLE:    o_ready = 1'b1;
            DONE:    o_valid = 1'b1;
            default: ;
        endcase
        accept = i_valid && o_ready;
    end

    // Datapath. Subtraction is a + ~b + 1, so b is inverted and the carry
    // preset on accept; the serial loop itself never knows it is subtracting.
    // Overflow is the carry into the MSB (still in 'carry' on the last
    // cycle) XOR the carry out of it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt     <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            carry   <= 1'b0;
            cry_reg <= 1'b0;
            ovf_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg   <= i_num_a;
                        b_reg   <= i_sub ? ~i_num_b : i_num_b;
                        carry   <= i_sub ? 1'b1 : i_cry;
                        cnt     <= '0;
                        res_reg <= '0;
                        cry_reg <= 1'b0;
                        ovf_reg <= 1'b0;
                    end
                end
                CALC: begin
                    res_reg[cnt] <= fa_sum;
                    carry        <= fa_cout;
                    if (last_bit) begin
                        cry_reg <= fa_cout;
                        ovf_reg <= carry ^ fa_cout;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_res = res_reg;
    assign o_cry = cry_reg;
    assign o_ovf = ovf_reg;

endmodule

// File: tb/tb_adder_serial_ctrl.sv
// ---------------------------------------------------------------------------
// tb_adder_serial_ctrl
//
// Directed bench for adder_serial_ctrl. Three instances (DATA_WIDTH 8, 1 and
// 32) share one stimulus set; 'sel' picks which instance sees i_valid and
// whose outputs are observed. Expected values are hand-computed for the
// directed cases and come from plain integer arithmetic for the streams.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_adder_serial_ctrl;

    logic        clk;
    logic        rst;
    logic        svalid;
    logic        sready;
    logic [63:0] sa;
    logic [63:0] sb;
    logic        scry;
    logic        ssub;
    int          sel;

    int checks;
    int errors;

    logic        v8, v1, v32;
    logic        rdy8, rdy1, rdy32;
    logic        val8, val1, val32;
    logic [7:0]  res8;
    logic [0:0]  res1;
    logic [31:0] res32;
    logic        cry8, cry1, cry32;
    logic        ovf8, ovf1, ovf32;

    logic        obs_ready;
    logic        obs_valid;
    logic [63:0] obs_res;
    logic        obs_cry;
    logic        obs_ovf;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign v8  = svalid && (sel == 8);
    assign v1  = svalid && (sel == 1);
    assign v32 = svalid && (sel == 32);

    adder_serial_ctrl #(.DATA_WIDTH(8)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_valid(v8), .o_ready(rdy8),
        .i_num_a(sa[7:0]), .i_num_b(sb[7:0]), .i_cry(scry), .i_sub(ssub),
        .o_valid(val8), .i_ready(sready), .o_res(res8), .o_cry(cry8), .o_ovf(ovf8)
    );

    adder_serial_ctrl #(.DATA_WIDTH(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_valid(v1), .o_ready(rdy1),
        .i_num_a(sa[0:0]), .i_num_b(sb[0:0]), .i_cry(scry), .i_sub(ssub),
        .o_valid(val1), .i_ready(sready), .o_res(res1), .o_cry(cry1), .o_ovf(ovf1)
    );

    adder_serial_ctrl #(.DATA_WIDTH(32)) dut32 (
        .i_clk(clk), .i_rst(rst), .i_valid(v32), .o_ready(rdy32),
        .i_num_a(sa[31:0]), .i_num_b(sb[31:0]), .i_cry(scry), .i_sub(ssub),
        .o_valid(val32), .i_ready(sready), .o_res(res32), .o_cry(cry32), .o_ovf(ovf32)
    );

    // Route the selected instance's outputs to one set of observation signals
    always_comb begin
        obs_ready = 1'b0;
        obs_valid = 1'b0;
        obs_res   = '0;
        obs_cry   = 1'b0;
        obs_ovf   = 1'b0;
        case (sel)
            1: begin
                obs_ready = rdy1;  obs_valid = val1;  obs_res = {63'd0, res1};
                obs_cry   = cry1;  obs_ovf   = ovf1;
            end
            8: begin
                obs_ready = rdy8;  obs_valid = val8;  obs_res = {56'd0, res8};
                obs_cry   = cry8;  obs_ovf   = ovf8;
            end
            32: begin
                obs_ready = rdy32; obs_valid = val32; obs_res = {32'd0, res32};
                obs_cry   = cry32; obs_ovf   = ovf32;
            end
            default: ;
        endcase
    end

    // Advance one clock; sampling and driving happen 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b,
                                 input logic cry, input logic sub);
        sa     = a;
        sb     = b;
        scry   = cry;
        ssub   = sub;
        svalid = 1'b1;
    endtask

    // Count cycles until o_valid rises; an expired bound is reported as a
    // failed comparison on o_valid
    task automatic waitValid(output int n);
        n = 0;
        while (!obs_valid && n < 200) begin
            tick();
            n++;
        end
        if (!obs_valid) checkOutput("valid_timeout", {63'd0, obs_valid}, 64'd1);
    endtask

    // One full directed transaction with the consumer always ready.
    // Operands are scrambled right after the accept edge to show they are
    // only sampled on that edge.
    task automatic doOp(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic cry, input logic sub, input int lat,
                        input logic [63:0] eres, input logic ecry, input logic eovf);
        int n;
        sready = 1'b1;
        applyStimulus(a, b, cry, sub);
        checkOutput({tag, "_ready"}, {63'd0, obs_ready}, 64'd1);
        tick();
        svalid = 1'b0;
        sa = ~a;
        sb = ~b;
        scry = ~cry;
        ssub = ~sub;
        checkOutput({tag, "_busy"}, {63'd0, obs_ready}, 64'd0);
        waitValid(n);
        checkOutput({tag, "_lat"}, 64'(n), 64'(lat));
        checkOutput({tag, "_res"}, obs_res, eres);
        checkOutput({tag, "_cry"}, {63'd0, obs_cry}, {63'd0, ecry});
        checkOutput({tag, "_ovf"}, {63'd0, obs_ovf}, {63'd0, eovf});
        tick();
        checkOutput({tag, "_idle"}, {63'd0, obs_ready}, 64'd1);
    endtask

    // Back-to-back random stream: i_valid stays high and the next operands
    // are presented as soon as the current ones are accepted, so spacing
    // between results is set by the engine alone.
    task automatic runStream(input int w, input int nops);
        logic [63:0] mask, a, b, bb, full, eres;
        logic        c, s, cin, ecry, eovf;
        int          n;
        mask = (64'd1 << w) - 64'd1;
        a = {$urandom, $urandom} & mask;
        b = {$urandom, $urandom} & mask;
        c = 1'($urandom_range(1));
        s = 1'($urandom_range(1));
        sready = 1'b1;
        applyStimulus(a, b, c, s);
        for (int k = 0; k < nops; k++) begin
            cin  = s ? 1'b1 : c;
            bb   = s ? (~b & mask) : b;
            full = a + bb + {63'd0, cin};
            eres = full & mask;
            ecry = full[w];
            eovf = (a[w-1] == bb[w-1]) && (eres[w-1] != a[w-1]);
            checkOutput("str_ready", {63'd0, obs_ready}, 64'd1);
            tick();
            a = {$urandom, $urandom} & mask;
            b = {$urandom, $urandom} & mask;
            c = 1'($urandom_range(1));
            s = 1'($urandom_range(1));
            applyStimulus(a, b, c, s);
            waitValid(n);
            checkOutput("str_spacing", 64'(n), 64'(w));
            checkOutput("str_res", obs_res, eres);
            checkOutput("str_cry", {63'd0, obs_cry}, {63'd0, ecry});
            checkOutput("str_ovf", {63'd0, obs_ovf}, {63'd0, eovf});
            tick();
        end
        svalid = 1'b0;
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        sel    = 8;
        rst    = 1'b1;
        svalid = 1'b0;
        sready = 1'b0;
        sa     = '0;
        sb     = '0;
        scry   = 1'b0;
        ssub   = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_ready", {63'd0, obs_ready}, 64'd1);
        checkOutput("rst_valid", {63'd0, obs_valid}, 64'd0);
        checkOutput("rst_res",   obs_res, 64'd0);
        checkOutput("rst_cry",   {63'd0, obs_cry}, 64'd0);
        checkOutput("rst_ovf",   {63'd0, obs_ovf}, 64'd0);

        $display("[TB] directed add/sub, width 8");
        doOp("ff_01",  64'hFF, 64'h01, 1'b0, 1'b0, 8, 64'h00, 1'b1, 1'b0);
        doOp("7f_01",  64'h7F, 64'h01, 1'b0, 1'b0, 8, 64'h80, 1'b0, 1'b1);
        doOp("10_20c", 64'h10, 64'h20, 1'b1, 1'b0, 8, 64'h31, 1'b0, 1'b0);
        doOp("05m07",  64'h05, 64'h07, 1'b1, 1'b1, 8, 64'hFE, 1'b0, 1'b0);
        doOp("80m01",  64'h80, 64'h01, 1'b0, 1'b1, 8, 64'h7F, 1'b1, 1'b1);

        $display("[TB] backpressure");
        sready = 1'b0;
        applyStimulus(64'h12, 64'h34, 1'b0, 1'b0);
        tick();
        svalid = 1'b0;
        waitValid(n);
        checkOutput("bp_res0", obs_res, 64'h46);
        for (int k = 0; k < 5; k++) begin
            svalid = ~svalid;
            sa = 64'(k * 37);
            sb = 64'(k * 11);
            ssub = ~ssub;
            tick();
            checkOutput("bp_valid", {63'd0, obs_valid}, 64'd1);
            checkOutput("bp_ready", {63'd0, obs_ready}, 64'd0);
            checkOutput("bp_res",   obs_res, 64'h46);
        end
        svalid = 1'b0;
        ssub   = 1'b0;
        sready = 1'b1;
        tick();
        checkOutput("bp_rel_ready", {63'd0, obs_ready}, 64'd1);
        checkOutput("bp_rel_valid", {63'd0, obs_valid}, 64'd0);
        checkOutput("bp_rel_hold",  obs_res, 64'h46);

        $display("[TB] reset during CALC");
        applyStimulus(64'hAA, 64'h55, 1'b0, 1'b0);
        tick();
        svalid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mr_ready", {63'd0, obs_ready}, 64'd1);
        checkOutput("mr_valid", {63'd0, obs_valid}, 64'd0);
        checkOutput("mr_res",   obs_res, 64'd0);
        checkOutput("mr_cry",   {63'd0, obs_cry}, 64'd0);
        for (int k = 0; k < 10; k++) tick();
        checkOutput("mr_novalid", {63'd0, obs_valid}, 64'd0);
        doOp("03_04", 64'h03, 64'h04, 1'b0, 1'b0, 8, 64'h07, 1'b0, 1'b0);

        $display("[TB] random stream, width 32");
        sel = 32;
        runStream(32, 100);

        $display("[TB] random stream, width 1");
        sel = 1;
        doOp("w1_1p1", 64'h1, 64'h1, 1'b0, 1'b0, 1, 64'h0, 1'b1, 1'b1);
        runStream(1, 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
